// File: rtl/bus_demux_1x2.sv
// bus_demux_1x2: routes one request stream to two downstream ports and merges their responses in acceptance order.
// Define BUS_DEMUX_ERR_EN to answer misaligned requests locally with an error response instead of forwarding them.
module bus_demux_1x2 #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_we,

    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [31:0] out0_addr,
    output logic [31:0] out0_wdata,
    output logic        out0_we,

    output logic        out1_valid,
    input  logic        out1_ready,
    output logic [31:0] out1_addr,
    output logic [31:0] out1_wdata,
    output logic        out1_we,

    input  logic        rsp0_valid,
    output logic        rsp0_ready,
    input  logic [31:0] rsp0_rdata,

    input  logic        rsp1_valid,
    output logic        rsp1_ready,
    input  logic [31:0] rsp1_rdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

    typedef enum logic [1:0] {
        TAG_PORT0 = 2'd0,
        TAG_PORT1 = 2'd1,
        TAG_ERR   = 2'd2
    } tag_t;

    logic          stageValid;
    logic          stagePort;
    logic [31:0]   stageAddr;
    logic [31:0]   stageWdata;
    logic          stageWe;

    tag_t          tagMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;

    logic          stageFire;
    logic          accept;
    logic          misaligned;
    logic          pop;
    logic          fifoEmpty;
    tag_t          pushTag;
    tag_t          headTag;

    // Full check uses only the registered count, so a same-cycle pop never frees a slot early.
    assign stageFire = stageValid && (stagePort ? out1_ready : out0_ready);
    assign in_ready  = (!stageValid || stageFire) && (count < FULL_COUNT);
    assign accept    = in_valid && in_ready;

`ifdef BUS_DEMUX_ERR_EN
    assign misaligned = (in_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        pushTag = TAG_PORT0;
        if (misaligned)
            pushTag = TAG_ERR;
        else if (in_addr >= MMIO_BASE)
            pushTag = TAG_PORT1;
    end

    // Misaligned requests bypass the stage; only their tag is queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            stageValid <= 1'b0;
            stagePort  <= 1'b0;
            stageAddr  <= '0;
            stageWdata <= '0;
            stageWe    <= 1'b0;
        end else if (accept && !misaligned) begin
            stageValid <= 1'b1;
            stagePort  <= (pushTag == TAG_PORT1);
            stageAddr  <= in_addr;
            stageWdata <= in_wdata;
            stageWe    <= in_we;
        end else if (stageFire) begin
            stageValid <= 1'b0;
        end
    end

    assign out0_valid = stageValid && !stagePort;
    assign out1_valid = stageValid && stagePort;
    assign out0_addr  = stageAddr;
    assign out1_addr  = stageAddr;
    assign out0_wdata = stageWdata;
    assign out1_wdata = stageWdata;
    assign out0_we    = stageWe;
    assign out1_we    = stageWe;

    always_ff @(posedge clk) begin
        if (accept)
            tagMem[wrPtr] <= pushTag;
    end

    assign fifoEmpty = (count == '0);
    assign headTag   = tagMem[rdPtr];
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (accept)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            if (accept && !pop)
                count <= count + 1'b1;
            else if (pop && !accept)
                count <= count - 1'b1;
        end
    end

    // Only the port owning the head tag sees rsp_ready; the other stalls until its turn.
    always_comb begin
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (!fifoEmpty) begin
            case (headTag)
                TAG_PORT0: begin
                    rsp_valid  = rsp0_valid;
                    rsp_rdata  = rsp0_rdata;
                    rsp0_ready = rsp_ready;
                end
                TAG_PORT1: begin
                    rsp_valid  = rsp1_valid;
                    rsp_rdata  = rsp1_rdata;
                    rsp1_ready = rsp_ready;
                end
                default: begin
                    rsp_valid = 1'b1;
`ifdef BUS_DEMUX_ERR_EN
                    rsp_err   = 1'b1;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_demux_1x2.sv
// Testbench for bus_demux_1x2: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_bus_demux_1x2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_we;
    logic [31:0] in_addr, in_wdata;
    logic        out0_valid, out0_ready, out0_we;
    logic [31:0] out0_addr, out0_wdata;
    logic        out1_valid, out1_ready, out1_we;
    logic [31:0] out1_addr, out1_wdata;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_rdata;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    bus_demux_1x2 #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata), .in_we(in_we),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_addr(out0_addr), .out0_wdata(out0_wdata), .out0_we(out0_we),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_addr(out1_addr), .out1_wdata(out1_wdata), .out1_we(out1_we),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inValid;
        logic [31:0] inAddr;
        logic [31:0] inWdata;
        logic        inWe;
        logic        o0Ready;
        logic        o1Ready;
        logic        r0Valid;
        logic [31:0] r0Data;
        logic        r1Valid;
        logic [31:0] r1Data;
        logic        rspReady;
    } stim_t;

    typedef struct {
        logic        inReady;
        logic        o0Valid;
        logic        o1Valid;
        logic        chkStage;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        rspValid;
        logic [31:0] rdata;
        logic        r0Ready;
        logic        r1Ready;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    vec_t        vecs [9];
    req_t        outQ [$];
    logic        orderQ [$];
    logic [31:0] respQ0 [$];
    logic [31:0] respQ1 [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        in_valid   = 1'b0; in_addr = '0; in_wdata = '0; in_we = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        rsp0_valid = 1'b0; rsp0_rdata = '0;
        rsp1_valid = 1'b0; rsp1_rdata = '0;
        rsp_ready  = 1'b0;
    endtask

    task automatic applyStimulus(input stim_t s);
        in_valid   = s.inValid;  in_addr = s.inAddr; in_wdata = s.inWdata; in_we = s.inWe;
        out0_ready = s.o0Ready;  out1_ready = s.o1Ready;
        rsp0_valid = s.r0Valid;  rsp0_rdata = s.r0Data;
        rsp1_valid = s.r1Valid;  rsp1_rdata = s.r1Data;
        rsp_ready  = s.rspReady;
    endtask

    task automatic doReset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Table rows run back to back from reset; each row's expectations reflect the state left by earlier rows.
    task automatic runTable();
        vecs[0] = '{'{1'b1, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0},
                    '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};
        vecs[1] = '{'{1'b1, 32'h1000_0000, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1},
                    '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0}};
        vecs[2] = '{'{1'b1, 32'h1000_0000, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1},
                    '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0}};
        vecs[3] = '{'{1'b1, 32'h0FFF_FFFC, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1},
                    '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h55, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}};
        vecs[4] = '{'{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111, 1'b0, 32'h0, 1'b1},
                    '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0FFF_FFFC, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}};
        vecs[5] = '{'{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111, 1'b1, 32'h2222, 1'b1},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2222, 1'b0, 1'b1}};
        vecs[6] = '{'{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111, 1'b0, 32'h0, 1'b0},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111, 1'b0, 1'b0}};
        vecs[7] = '{'{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111, 1'b0, 32'h0, 1'b1},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111, 1'b1, 1'b0}};
        vecs[8] = '{'{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333, 1'b1, 32'h4444, 1'b1},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};
        doReset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].s);
            #1;
            checkOutput($sformatf("row%0d in_ready", i), in_ready, vecs[i].e.inReady);
            checkOutput($sformatf("row%0d out0_valid", i), out0_valid, vecs[i].e.o0Valid);
            checkOutput($sformatf("row%0d out1_valid", i), out1_valid, vecs[i].e.o1Valid);
            checkOutput($sformatf("row%0d rsp_valid", i), rsp_valid, vecs[i].e.rspValid);
            checkOutput($sformatf("row%0d rsp0_ready", i), rsp0_ready, vecs[i].e.r0Ready);
            checkOutput($sformatf("row%0d rsp1_ready", i), rsp1_ready, vecs[i].e.r1Ready);
            checkOutput($sformatf("row%0d rsp_err", i), rsp_err, 1'b0);
            if (vecs[i].e.rspValid)
                checkOutput($sformatf("row%0d rsp_rdata", i), rsp_rdata, vecs[i].e.rdata);
            if (vecs[i].e.chkStage) begin
                checkOutput($sformatf("row%0d out0_addr", i), out0_addr, vecs[i].e.addr);
                checkOutput($sformatf("row%0d out1_addr", i), out1_addr, vecs[i].e.addr);
                checkOutput($sformatf("row%0d out1_wdata", i), out1_wdata, vecs[i].e.wdata);
                checkOutput($sformatf("row%0d out0_we", i), out0_we, vecs[i].e.we);
            end
        end
    endtask

    // Read to port 0 answered three cycles after acceptance.
    task automatic seqLatency();
        doReset();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h0000_0010; in_we = 1'b0; out0_ready = 1'b1;
        #1;
        checkOutput("lat in_ready", in_ready, 1'b1);
        checkOutput("lat out0_valid before", out0_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("lat out0_valid", out0_valid, 1'b1);
        checkOutput("lat out1_valid", out1_valid, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("lat rsp_valid early", rsp_valid, 1'b0);
        @(negedge clk);
        rsp0_valid = 1'b1; rsp0_rdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
        #1;
        checkOutput("lat rsp_valid", rsp_valid, 1'b1);
        checkOutput("lat rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("lat rsp_err", rsp_err, 1'b0);
        checkOutput("lat rsp0_ready", rsp0_ready, 1'b1);
        @(negedge clk);
        rsp0_valid = 1'b0;
        #1;
        checkOutput("lat rsp_valid after pop", rsp_valid, 1'b0);
    endtask

    // Withheld responses fill the tag FIFO; a pop frees a slot only on the following cycle.
    task automatic seqFull();
        doReset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = 32'(k * 16); out0_ready = 1'b1; out1_ready = 1'b1;
            #1;
            checkOutput($sformatf("full in_ready k%0d", k), in_ready, (k < 4) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        rsp0_valid = 1'b1; rsp0_rdata = 32'hABCD; rsp_ready = 1'b1;
        #1;
        checkOutput("full rsp_valid", rsp_valid, 1'b1);
        checkOutput("full in_ready at pop", in_ready, 1'b0);
        @(negedge clk);
        rsp0_valid = 1'b0;
        #1;
        checkOutput("full in_ready after pop", in_ready, 1'b1);
    endtask

    // Reset with two tags outstanding and the stage occupied.
    task automatic seqReset();
        doReset();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h1000_0004; in_wdata = 32'h99; in_we = 1'b1;
        @(negedge clk);
        in_addr = 32'h0000_0020; out1_ready = 1'b1;
        #1;
        checkOutput("rst in_ready second", in_ready, 1'b1);
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        checkOutput("rst out0_valid before", out0_valid, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst out0_valid", out0_valid, 1'b0);
        checkOutput("rst out1_valid", out1_valid, 1'b0);
        checkOutput("rst rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst rsp_err", rsp_err, 1'b0);
        checkOutput("rst in_ready", in_ready, 1'b1);
        checkOutput("rst out0_addr", out0_addr, 32'h0);
        checkOutput("rst out1_wdata", out1_wdata, 32'h0);
        checkOutput("rst out1_we", out1_we, 1'b0);
        @(negedge clk);
        rsp0_valid = 1'b1; rsp0_rdata = 32'h5A5A; rsp1_valid = 1'b1; rsp1_rdata = 32'hA5A5; rsp_ready = 1'b1;
        #1;
        checkOutput("rst late rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst late rsp0_ready", rsp0_ready, 1'b0);
        checkOutput("rst late rsp1_ready", rsp1_ready, 1'b0);
    endtask

`ifdef BUS_DEMUX_ERR_EN
    task automatic seqError();
        doReset();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h0000_0006; out0_ready = 1'b1; out1_ready = 1'b1;
        #1;
        checkOutput("err in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        checkOutput("err out0_valid", out0_valid, 1'b0);
        checkOutput("err out1_valid", out1_valid, 1'b0);
        checkOutput("err rsp_valid", rsp_valid, 1'b1);
        checkOutput("err rsp_err", rsp_err, 1'b1);
        checkOutput("err rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("err rsp0_ready", rsp0_ready, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("err rsp_valid after pop", rsp_valid, 1'b0);
        checkOutput("err rsp_err after pop", rsp_err, 1'b0);
    endtask
`endif

    // Random traffic against a transaction-level model: pending forwards, merge order, and per-port response data.
    task automatic runRandom(input int cycles);
        logic [31:0] r;
        logic [31:0] a;
        logic        expIn, expO0, expO1, expRspV, expR0r, expR1r, p, acc, newPort;
        int          nRsp;
        req_t        fwd;
        nRsp = 0;
        outQ.delete(); orderQ.delete(); respQ0.delete(); respQ1.delete();
        doReset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: a = {4'h0, r[27:0]};
                1: a = r | BASE;
                2: a = BASE;
                default: a = BASE - 32'd4;
            endcase
            a[1:0] = 2'b00;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_addr    = a;
            in_wdata   = $urandom;
            in_we      = 1'($urandom_range(0, 1));
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            rsp0_valid = (respQ0.size() > 0) && ($urandom_range(0, 2) != 0);
            rsp0_rdata = rsp0_valid ? respQ0[0] : $urandom;
            rsp1_valid = (respQ1.size() > 0) && ($urandom_range(0, 2) != 0);
            rsp1_rdata = rsp1_valid ? respQ1[0] : $urandom;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            #1;
            expO0 = (outQ.size() > 0) && (outQ[0].port == 1'b0);
            expO1 = (outQ.size() > 0) && (outQ[0].port == 1'b1);
            expIn = ((outQ.size() == 0) || (expO0 && out0_ready) || (expO1 && out1_ready)) && (orderQ.size() < DEPTH);
            p = 1'b0; expRspV = 1'b0; expR0r = 1'b0; expR1r = 1'b0;
            if (orderQ.size() > 0) begin
                p       = orderQ[0];
                expRspV = p ? rsp1_valid : rsp0_valid;
                expR0r  = !p && rsp_ready;
                expR1r  = p && rsp_ready;
            end
            checkOutput("rand in_ready", in_ready, expIn);
            checkOutput("rand out0_valid", out0_valid, expO0);
            checkOutput("rand out1_valid", out1_valid, expO1);
            checkOutput("rand rsp_valid", rsp_valid, expRspV);
            checkOutput("rand rsp0_ready", rsp0_ready, expR0r);
            checkOutput("rand rsp1_ready", rsp1_ready, expR1r);
            checkOutput("rand rsp_err", rsp_err, 1'b0);
            if (expRspV)
                checkOutput("rand rsp_rdata", rsp_rdata, p ? respQ1[0] : respQ0[0]);
            if (expO0 || expO1) begin
                fwd = outQ[0];
                checkOutput("rand out_addr", expO1 ? out1_addr : out0_addr, fwd.addr);
                checkOutput("rand out_wdata", expO1 ? out1_wdata : out0_wdata, fwd.wdata);
                checkOutput("rand out_we", expO1 ? out1_we : out0_we, fwd.we);
            end
            acc = in_valid && expIn;
            if (expRspV && rsp_ready) begin
                if (p) void'(respQ1.pop_front());
                else   void'(respQ0.pop_front());
                void'(orderQ.pop_front());
                nRsp++;
            end
            if (expO0 && out0_ready) begin
                void'(outQ.pop_front());
                respQ0.push_back($urandom);
            end else if (expO1 && out1_ready) begin
                void'(outQ.pop_front());
                respQ1.push_back($urandom);
            end
            if (acc) begin
                newPort = (a >= BASE);
                outQ.push_back('{newPort, a, in_wdata, in_we});
                orderQ.push_back(newPort);
            end
        end
        checkOutput("rand progress", (nRsp > 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        $display("[TB] starting bus_demux_1x2 bench");
        runTable();
        seqLatency();
        seqFull();
        seqReset();
`ifdef BUS_DEMUX_ERR_EN
        seqError();
`endif
        runRandom(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_demux_1x2.md
BUS_DEMUX_1X2 -- requirements
Module: bus_demux_1x2

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of outstanding-request tags (power of two, at least 2).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h1000_0000; addresses at or above it route to port 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have upstream request ports in_valid (in, 1), in_ready (out, 1), in_addr (in, 32), in_wdata (in, 32) and in_we (in, 1).
REQ-006 SHALL have, for each port n in {0,1}, request ports outn_valid (out, 1), outn_ready (in, 1), outn_addr (out, 32), outn_wdata (out, 32) and outn_we (out, 1).
REQ-007 SHALL have, for each port n, response ports rspn_valid (in, 1), rspn_ready (out, 1) and rspn_rdata (in, 32).
REQ-008 SHALL have merged response ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, 32) and rsp_err (out, 1).

Function
REQ-009 SHALL accept a request on a cycle where in_valid and in_ready are both 1.
REQ-010 SHALL route each accepted request to port 1 when in_addr >= MMIO_BASE (unsigned compare), otherwise to port 0.
REQ-011 SHALL hold the accepted request in a one-entry stage register, presented on the selected port only, with a latency of 1 cycle from acceptance to outn_valid=1.
REQ-012 SHALL hold the non-selected port's valid at 0, and its addr, wdata and we outputs at the stage-register contents.
REQ-013 SHALL keep outn_valid, addr, wdata and we stable until the cycle where outn_ready=1.
REQ-014 SHALL compute in_ready = (stage empty OR stage firing this cycle) AND tag count < DEPTH, allowing back-to-back acceptance.
REQ-015 SHALL, on acceptance, push a destination tag (0, 1, or 2 = error) into a DEPTH-entry tag FIFO.
REQ-016 SHALL base the full check on the registered tag count only: no acceptance while full, even when a pop occurs in the same cycle.
REQ-017 SHALL produce exactly one merged response per accepted request, reads and writes alike, in acceptance order.
REQ-018 SHALL, when the head tag is n, drive rsp_valid = rspn_valid, rsp_rdata = rspn_rdata and rspn_ready = rsp_ready combinationally.
REQ-019 SHALL, when the head tag is n, hold the other port's rsp ready at 0.
REQ-020 SHALL hold all rspn_ready at 0 and rsp_valid at 0 when the tag FIFO is empty.
REQ-021 SHALL pop the tag FIFO on rsp_valid AND rsp_ready.
REQ-022 SHALL perform a simultaneous push and pop without changing the count, with wrap-around of the read and write pointers modulo DEPTH.
REQ-023 SHALL ignore a response presented by a port whose tag is not at the FIFO head, leaving it stalled until that tag reaches the head.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, empty the stage register and the tag FIFO, and zero the pointers and count.
REQ-025 SHALL, following such a reset edge, drive out0_valid=0, out1_valid=0, rsp_valid=0, rsp_err=0 and in_ready=1 (in_ready once rst returns to 0).
REQ-026 SHALL, following such a reset edge, drive all addr, wdata and we outputs to 0.
REQ-027 SHALL discard an in-flight request or outstanding tag when reset is asserted mid-transaction, with no response emitted for it.

Configuration
REQ-028 SHALL, with macro BUS_DEMUX_ERR_EN defined, treat an accepted request with in_addr[1:0] != 0 as misaligned.
REQ-029 SHALL not forward a misaligned request to any port, shall not occupy the stage register with it, and shall push tag 2 for it.
REQ-030 SHALL, with tag 2 at the FIFO head, present rsp_valid=1, rsp_rdata=0 and rsp_err=1.
REQ-031 SHALL, without BUS_DEMUX_ERR_EN, forward all addresses unmodified, never generate tag 2, and tie rsp_err to 0.

Verification
REQ-032 SHALL cover: read to 0x0000_0010, port 0 responds 0xDEAD_BEEF 3 cycles later -> out0_valid one cycle after acceptance; rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-033 SHALL cover: request to 0x1000_0000, then to 0x0FFF_FFFC -> first routed to port 1, second to port 0.
REQ-034 SHALL cover: port 1 then port 0 requests, with port 0 responding first -> rsp0_ready held 0 until port 1's response pops; merged order is port 1 then port 0.
REQ-035 SHALL cover: DEPTH=4 with responses withheld, five back-to-back requests -> in_ready=0 after the fourth acceptance, and =1 again the cycle after the first pop.
REQ-036 SHALL cover: rst=1 for one cycle with two tags outstanding and the stage full -> next cycle count=0, all valids 0, late port responses ignored.
REQ-037 SHALL cover: with BUS_DEMUX_ERR_EN, read to 0x0000_0006 -> no outn_valid, rsp_valid=1, rsp_err=1, rsp_rdata=0.
